// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 8N1 UART receiver feeding a first-word-fall-through byte FIFO,
// with sticky framing and overflow flags.
`default_nettype none

module uart_rx_fifo #(
    parameter int CLK_HZ     = 12_000_000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic                          rx,
    input  logic                          rd_en,
    output logic [7:0]                    dout,
    output logic                          empty,
    output logic                          full,
    output logic [$clog2(FIFO_DEPTH):0]   count,
    output logic                          frame_err,
    output logic                          overflow,
    input  logic                          clr_err
);

    localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
    localparam int CW           = $clog2(CLKS_PER_BIT);
    localparam int AW           = $clog2(FIFO_DEPTH);
    localparam int CNTW         = AW + 1;

    localparam logic [CW-1:0]   HALF_RELOAD = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0]   BIT_RELOAD  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0]   CNT_ZERO    = '0;
    localparam logic [CNTW-1:0] FULL_CNT    = CNTW'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_STOP  = 3'd3,
        S_BREAK = 3'd4
    } state_t;

    // rx synchroniser, preset to the idle line level
    logic rx_meta;
    logic rx_s;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    state_t        state, state_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic [2:0]    bit_idx, bit_nx;
    logic [7:0]    shreg, shreg_nx;
    logic          push;
    logic          ferr_set;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state   <= S_IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
        end else begin
            state   <= state_nx;
            cnt     <= cnt_nx;
            bit_idx <= bit_nx;
            shreg   <= shreg_nx;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        bit_nx   = bit_idx;
        shreg_nx = shreg;
        push     = 1'b0;
        ferr_set = 1'b0;
        case (state)
            S_IDLE: begin
                if (!rx_s) begin
                    state_nx = S_START;
                    cnt_nx   = HALF_RELOAD;
                end
            end
            S_START: begin
                if (cnt == CNT_ZERO) begin
                    if (!rx_s) begin
                        state_nx = S_DATA;
                        cnt_nx   = BIT_RELOAD;
                        bit_nx   = 3'd0;
                    end else begin
                        state_nx = S_IDLE;
                    end
                end else begin
                    cnt_nx = cnt - CW'(1);
                end
            end
            S_DATA: begin
                if (cnt == CNT_ZERO) begin
                    shreg_nx[bit_idx] = rx_s;
                    cnt_nx            = BIT_RELOAD;
                    bit_nx            = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) begin
                        state_nx = S_STOP;
                    end
                end else begin
                    cnt_nx = cnt - CW'(1);
                end
            end
            S_STOP: begin
                if (cnt == CNT_ZERO) begin
                    if (rx_s) begin
                        push     = 1'b1;
                        state_nx = S_IDLE;
                    end else begin
                        ferr_set = 1'b1;
                        state_nx = S_BREAK;
                    end
                end else begin
                    cnt_nx = cnt - CW'(1);
                end
            end
            S_BREAK: begin
                // one error per low period; wait for the line to return high
                if (rx_s) begin
                    state_nx = S_IDLE;
                end
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic          do_pop;
    logic          do_push;
    logic          ovf_set;

    assign empty   = (count == '0);
    assign full    = (count == FULL_CNT);
    assign do_pop  = rd_en && !empty;
    // a same-cycle pop frees the slot the push needs
    assign do_push = push && (!full || do_pop);
    assign ovf_set = push && full && !do_pop;
    assign dout    = empty ? 8'h00 : mem[rptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wptr] <= shreg;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) begin
                wptr <= wptr + AW'(1);
            end
            if (do_pop) begin
                rptr <= rptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNTW'(1);
                2'b01:   count <= count - CNTW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            frame_err <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            if (ferr_set) begin
                frame_err <= 1'b1;
            end else if (clr_err) begin
                frame_err <= 1'b0;
            end
            if (ovf_set) begin
                overflow <= 1'b1;
            end else if (clr_err) begin
                overflow <= 1'b0;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo at 10 clk/bit with a 4-entry FIFO.
`default_nettype none

module tb_uart_rx_fifo;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       rx = 1'b1;
    logic       rd_en = 1'b0;
    logic       clr_err = 1'b0;
    logic [7:0] dout;
    logic       empty;
    logic       full;
    logic [2:0] count;
    logic       frame_err;
    logic       overflow;

    int total = 0;
    int passed = 0;

    uart_rx_fifo #(
        .CLK_HZ    (1_000_000),
        .BAUD      (100_000),
        .FIFO_DEPTH(4)
    ) dut (
        .clk      (clk),
        .resetn   (resetn),
        .rx       (rx),
        .rd_en    (rd_en),
        .dout     (dout),
        .empty    (empty),
        .full     (full),
        .count    (count),
        .frame_err(frame_err),
        .overflow (overflow),
        .clr_err  (clr_err)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, actual=running required=finished");
        $fatal(1);
    end

    // Must be entered at a negedge. The stop-bit sample/push edge is the posedge
    // right after stop-bit negedge 7, which is where the optional strobes land.
    task automatic send_byte(input logic [7:0] b, input logic stop_bit,
                             input bit pop_on_push, input bit clr_on_push, input int rst_bit);
        rx = 1'b0;
        repeat (10) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            for (int j = 0; j < 10; j++) begin
                resetn = !(i == rst_bit && j == 5);
                @(negedge clk);
            end
        end
        resetn = 1'b1;
        rx = stop_bit;
        for (int j = 0; j < 10; j++) begin
            if (pop_on_push) rd_en = (j == 7);
            if (clr_on_push) clr_err = (j == 7);
            @(negedge clk);
        end
        rd_en = 1'b0;
        clr_err = 1'b0;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        rx = 1'b1;
        repeat (3) @(negedge clk);
        total++; if (empty !== 1'b1) $display("FAIL reset_empty actual=%b required=1", empty); else passed++;
        total++; if (full !== 1'b0) $display("FAIL reset_full actual=%b required=0", full); else passed++;
        total++; if (count !== 3'd0) $display("FAIL reset_count actual=%0d required=0", count); else passed++;
        total++; if (dout !== 8'h00) $display("FAIL reset_dout actual=%h required=00", dout); else passed++;
        total++; if (frame_err !== 1'b0) $display("FAIL reset_frame_err actual=%b required=0", frame_err); else passed++;
        total++; if (overflow !== 1'b0) $display("FAIL reset_overflow actual=%b required=0", overflow); else passed++;
        resetn = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_single_byte();
        send_byte(8'hA5, 1'b1, 1'b0, 1'b0, -1);
        total++; if (empty !== 1'b0) $display("FAIL a5_empty actual=%b required=0", empty); else passed++;
        total++; if (dout !== 8'hA5) $display("FAIL a5_dout actual=%h required=a5", dout); else passed++;
        total++; if (count !== 3'd1) $display("FAIL a5_count actual=%0d required=1", count); else passed++;
        total++; if ({frame_err, overflow} !== 2'b00) $display("FAIL a5_flags actual=%b required=00", {frame_err, overflow}); else passed++;
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
        total++; if (empty !== 1'b1) $display("FAIL a5_pop_empty actual=%b required=1", empty); else passed++;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_glitch();
        rx = 1'b0;
        repeat (3) @(negedge clk);
        rx = 1'b1;
        repeat (120) @(negedge clk);
        total++; if (empty !== 1'b1) $display("FAIL glitch_empty actual=%b required=1", empty); else passed++;
        total++; if (frame_err !== 1'b0) $display("FAIL glitch_frame_err actual=%b required=0", frame_err); else passed++;
    endtask

    task automatic test_frame_error();
        // clr_err coincides with the failing stop sample: the new error must win
        send_byte(8'h3C, 1'b0, 1'b0, 1'b1, -1);
        total++; if (frame_err !== 1'b1) $display("FAIL ferr_set actual=%b required=1", frame_err); else passed++;
        total++; if (empty !== 1'b1) $display("FAIL ferr_empty actual=%b required=1", empty); else passed++;
        repeat (40) @(negedge clk);
        rx = 1'b1;
        repeat (150) @(negedge clk);
        total++; if (empty !== 1'b1) $display("FAIL break_no_byte actual_empty=%b required=1", empty); else passed++;
        total++; if (frame_err !== 1'b1) $display("FAIL ferr_sticky actual=%b required=1", frame_err); else passed++;
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        total++; if (frame_err !== 1'b0) $display("FAIL ferr_clear actual=%b required=0", frame_err); else passed++;
        send_byte(8'h11, 1'b1, 1'b0, 1'b0, -1);
        total++; if (dout !== 8'h11 || empty !== 1'b0) $display("FAIL after_ferr_dout actual=%h empty=%b required=11 empty=0", dout, empty); else passed++;
        total++; if (frame_err !== 1'b0) $display("FAIL after_ferr_flag actual=%b required=0", frame_err); else passed++;
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_overflow();
        logic [7:0] exp_b;
        for (int k = 1; k <= 5; k++) send_byte(8'(k), 1'b1, 1'b0, 1'b0, -1);
        repeat (3) @(negedge clk);
        total++; if (full !== 1'b1) $display("FAIL ovf_full actual=%b required=1", full); else passed++;
        total++; if (count !== 3'd4) $display("FAIL ovf_count actual=%0d required=4", count); else passed++;
        total++; if (overflow !== 1'b1) $display("FAIL ovf_flag actual=%b required=1", overflow); else passed++;
        for (int k = 1; k <= 4; k++) begin
            exp_b = 8'(k);
            total++; if (dout !== exp_b) $display("FAIL ovf_pop%0d actual=%h required=%h", k, dout, exp_b); else passed++;
            rd_en = 1'b1;
            @(negedge clk);
            rd_en = 1'b0;
        end
        total++; if (empty !== 1'b1) $display("FAIL ovf_drained actual=%b required=1", empty); else passed++;
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        total++; if (overflow !== 1'b0) $display("FAIL ovf_clear actual=%b required=0", overflow); else passed++;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_pop_push_full();
        logic [7:0] exp_q [4];
        exp_q = '{8'h11, 8'h12, 8'h13, 8'h55};
        for (int k = 0; k < 4; k++) send_byte(8'h10 + 8'(k), 1'b1, 1'b0, 1'b0, -1);
        total++; if (full !== 1'b1) $display("FAIL pp_prefull actual=%b required=1", full); else passed++;
        send_byte(8'h55, 1'b1, 1'b1, 1'b0, -1);
        total++; if (count !== 3'd4) $display("FAIL pp_count actual=%0d required=4", count); else passed++;
        total++; if (overflow !== 1'b0) $display("FAIL pp_overflow actual=%b required=0", overflow); else passed++;
        for (int k = 0; k < 4; k++) begin
            total++; if (dout !== exp_q[k]) $display("FAIL pp_pop%0d actual=%h required=%h", k, dout, exp_q[k]); else passed++;
            rd_en = 1'b1;
            @(negedge clk);
            rd_en = 1'b0;
        end
        total++; if (empty !== 1'b1) $display("FAIL pp_drained actual=%b required=1", empty); else passed++;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_midframe_reset();
        send_byte(8'h77, 1'b1, 1'b0, 1'b0, -1);
        total++; if (count !== 3'd1) $display("FAIL mr_preload actual=%0d required=1", count); else passed++;
        send_byte(8'hFF, 1'b1, 1'b0, 1'b0, 4);
        repeat (20) @(negedge clk);
        total++; if (empty !== 1'b1) $display("FAIL mr_flushed actual_empty=%b required=1", empty); else passed++;
        send_byte(8'h42, 1'b1, 1'b0, 1'b0, -1);
        total++; if (dout !== 8'h42 || count !== 3'd1) $display("FAIL mr_rx42 actual=%h count=%0d required=42 count=1", dout, count); else passed++;
        total++; if ({frame_err, overflow} !== 2'b00) $display("FAIL mr_flags actual=%b required=00", {frame_err, overflow}); else passed++;
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_single_byte();
        test_glitch();
        test_frame_error();
        test_overflow();
        test_pop_push_full();
        test_midframe_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

`default_nettype wire
